// File: rtl/traffic_pkg.sv
// Shared lamp encodings, direction indices and tracker phases for the
// traffic light monitor.
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  typedef enum logic [1:0] {DIR_N, DIR_S, DIR_E, DIR_W} dir_e;

  typedef enum logic [1:0] {PH_RED, PH_GREEN, PH_YELLOW} phase_e;

endpackage

// File: rtl/traffic_dir_tracker.sv
// Per-direction phase tracker: follows one lamp bus tick by tick and flags
// encoding, transition and dwell violations for the current sample.
module traffic_dir_tracker
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN    = 2,
  parameter int GREEN_MAX    = 10,
  parameter int YELLOW_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic       tick,
  input  logic [2:0] lights,
  output logic       non_red,
  output logic       to_green,
  output logic       to_red,
  output logic       enc_err,
  output logic       seq_err,
  output logic       tim_err
);

  localparam int              DW_W   = $clog2(GREEN_MAX + 2);
  localparam logic [DW_W-1:0] DW_SAT = DW_W'(GREEN_MAX + 1);

  phase_e          phase, phase_nxt, obs;
  logic [DW_W-1:0] dwell, dwell_nxt;
  logic            legal;

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      phase <= PH_RED;
      dwell <= '0;
    end else if (tick) begin
      phase <= phase_nxt;
      dwell <= dwell_nxt;
    end
  end

  always_comb begin
    phase_nxt = phase;
    dwell_nxt = dwell;
    obs       = PH_RED;
    legal     = 1'b1;
    to_green  = 1'b0;
    to_red    = 1'b0;
    seq_err   = 1'b0;
    tim_err   = 1'b0;
    non_red   = (lights != LIGHT_RED);
    case (lights)
      LIGHT_RED:    obs = PH_RED;
      LIGHT_YELLOW: obs = PH_YELLOW;
      LIGHT_GREEN:  obs = PH_GREEN;
      default:      legal = 1'b0;
    endcase
    enc_err = ~legal;
    // A malformed code leaves phase and dwell untouched.
    if (legal) begin
      if (obs == phase) begin
        if (dwell != DW_SAT) dwell_nxt = dwell + 1'b1;
        // Saturation keeps this from re-firing within the same green phase.
        if (phase == PH_GREEN && int'(dwell) + 1 == GREEN_MAX) tim_err = 1'b1;
      end else begin
        phase_nxt = obs;
        dwell_nxt = '0;
        case (phase)
          PH_RED: begin
            to_green = (obs == PH_GREEN);
            seq_err  = (obs == PH_YELLOW);
          end
          PH_GREEN: begin
            seq_err = (obs == PH_RED);
            tim_err = (obs == PH_YELLOW) && (int'(dwell) + 1 < GREEN_MIN);
          end
          PH_YELLOW: begin
            seq_err = (obs == PH_GREEN);
            to_red  = (obs == PH_RED);
            tim_err = (obs == PH_RED) && (int'(dwell) + 1 != YELLOW_TICKS);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for traffic_control outputs: safety, encoding, sequence
// and dwell checks with sticky flags, error count and rotation count.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN    = 2,
  parameter int GREEN_MAX    = 10,
  parameter int YELLOW_TICKS = 2,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_a,
  input  logic                 clk_out,
  input  logic [2:0]           n_lights,
  input  logic [2:0]           s_lights,
  input  logic [2:0]           e_lights,
  input  logic [2:0]           w_lights,
  input  logic                 clr_err,
  output logic                 err_conflict,
  output logic                 err_encoding,
  output logic                 err_sequence,
  output logic                 err_timing,
  output logic                 err_any,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [1:0]           active_dir,
  output logic                 active_valid,
  output logic [15:0]          rot_count
);

  logic       clk_out_q, tick;
  logic [2:0] lamps [4];
  logic [3:0] non_red, to_green, to_red, enc_err, seq_err, tim_err;
  logic [2:0] nr_cnt;
  logic [1:0] nr_idx;
  dir_e       exp_dir, exp_dir_nxt;
  logic       exp_any, exp_any_nxt;
  logic [2:0] prog, prog_nxt;
  logic       rot_seq_err, rot_inc;
  logic       c_conf, c_enc, c_seq, c_tim, c_any;

  assign lamps[0] = n_lights;
  assign lamps[1] = s_lights;
  assign lamps[2] = e_lights;
  assign lamps[3] = w_lights;

  // Falling edge of the strobe, half a strobe after the controller updates.
  assign tick = clk_out_q & ~clk_out;

  for (genvar i = 0; i < 4; i++) begin : g_dir
    traffic_dir_tracker #(
      .GREEN_MIN   (GREEN_MIN),
      .GREEN_MAX   (GREEN_MAX),
      .YELLOW_TICKS(YELLOW_TICKS)
    ) u_trk (
      .clk     (clk),
      .rst_a   (rst_a),
      .tick    (tick),
      .lights  (lamps[i]),
      .non_red (non_red[i]),
      .to_green(to_green[i]),
      .to_red  (to_red[i]),
      .enc_err (enc_err[i]),
      .seq_err (seq_err[i]),
      .tim_err (tim_err[i])
    );
  end

  always_comb begin
    nr_cnt = '0;
    nr_idx = '0;
    for (int d = 0; d < 4; d++) begin
      if (non_red[d]) begin
        nr_cnt = nr_cnt + 3'd1;
        nr_idx = 2'(d);
      end
    end
  end

  // prog counts how many of N,S,E,W have gone green in order so far.
  always_comb begin
    exp_any_nxt = exp_any;
    exp_dir_nxt = exp_dir;
    prog_nxt    = prog;
    rot_seq_err = 1'b0;
    rot_inc     = 1'b0;
    for (int d = 0; d < 4; d++) begin
      if (to_green[d]) begin
        if (!exp_any && exp_dir != dir_e'(2'(d))) rot_seq_err = 1'b1;
        exp_dir_nxt = dir_e'(2'(d + 1));
        exp_any_nxt = 1'b0;
        if (d == 0)                prog_nxt = 3'd1;
        else if (prog == 3'(d))    prog_nxt = 3'(d + 1);
        else                       prog_nxt = 3'd0;
      end
    end
    if (to_red[DIR_W] && prog_nxt == 3'd4) begin
      rot_inc  = 1'b1;
      prog_nxt = 3'd0;
    end
  end

  assign c_conf = (nr_cnt > 3'd1);
  assign c_enc  = |enc_err;
  assign c_seq  = (|seq_err) | rot_seq_err;
  assign c_tim  = |tim_err;
  assign c_any  = c_conf | c_enc | c_seq | c_tim;

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      clk_out_q    <= 1'b0;
      exp_any      <= 1'b1;
      exp_dir      <= DIR_N;
      prog         <= '0;
      rot_count    <= '0;
      active_dir   <= '0;
      active_valid <= 1'b0;
      err_conflict <= 1'b0;
      err_encoding <= 1'b0;
      err_sequence <= 1'b0;
      err_timing   <= 1'b0;
      err_count    <= '0;
    end else begin
      clk_out_q <= clk_out;
      if (tick) begin
        exp_any      <= exp_any_nxt;
        exp_dir      <= exp_dir_nxt;
        prog         <= prog_nxt;
        rot_count    <= rot_count + {15'd0, rot_inc};
        active_valid <= (nr_cnt == 3'd1);
        if (nr_cnt == 3'd1) active_dir <= nr_idx;
      end
      // A tick error coinciding with a clear survives the clear.
      if (clr_err) begin
        err_conflict <= tick & c_conf;
        err_encoding <= tick & c_enc;
        err_sequence <= tick & c_seq;
        err_timing   <= tick & c_tim;
        err_count    <= (tick && c_any) ? ERR_CNT_W'(1) : '0;
      end else if (tick) begin
        err_conflict <= err_conflict | c_conf;
        err_encoding <= err_encoding | c_enc;
        err_sequence <= err_sequence | c_seq;
        err_timing   <= err_timing | c_tim;
        if (c_any && err_count != '1) err_count <= err_count + 1'b1;
      end
    end
  end

  assign err_any = err_conflict | err_encoding | err_sequence | err_timing;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: hand-built lamp sequences with
// expected flag, count and direction values written out per scenario.
module tb_traffic_light_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic        clk = 1'b0;
  logic        rst_a, clk_out, clr_err;
  logic [2:0]  n_lights, s_lights, e_lights, w_lights;
  logic        err_conflict, err_encoding, err_sequence, err_timing, err_any;
  logic [7:0]  err_count;
  logic [1:0]  active_dir;
  logic        active_valid;
  logic [15:0] rot_count;

  int checks = 0;
  int fails  = 0;

  traffic_light_monitor #(
    .GREEN_MIN(2), .GREEN_MAX(10), .YELLOW_TICKS(2), .ERR_CNT_W(8)
  ) dut (
    .clk(clk), .rst_a(rst_a), .clk_out(clk_out),
    .n_lights(n_lights), .s_lights(s_lights), .e_lights(e_lights), .w_lights(w_lights),
    .clr_err(clr_err),
    .err_conflict(err_conflict), .err_encoding(err_encoding), .err_sequence(err_sequence),
    .err_timing(err_timing), .err_any(err_any), .err_count(err_count),
    .active_dir(active_dir), .active_valid(active_valid), .rot_count(rot_count)
  );

  always #5 clk = ~clk;

  // One strobe period: lamps change with clk_out high, sampled when it falls.
  task automatic tick_lamps(input logic [2:0] n, input logic [2:0] s,
                            input logic [2:0] e, input logic [2:0] w, input logic clr);
    @(negedge clk);
    n_lights = n; s_lights = s; e_lights = e; w_lights = w;
    clk_out = 1'b1;
    @(negedge clk);
    clk_out = 1'b0;
    clr_err = clr;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
  endtask

  task automatic tick_one(input int d, input logic [2:0] code);
    logic [2:0] l [4];
    for (int i = 0; i < 4; i++) l[i] = R;
    l[d] = code;
    tick_lamps(l[0], l[1], l[2], l[3], 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_a = 1'b0; clk_out = 1'b0; clr_err = 1'b0;
    n_lights = R; s_lights = R; e_lights = R; w_lights = R;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_a = 1'b0; clk_out = 1'b0; clr_err = 1'b0;
    n_lights = R; s_lights = R; e_lights = R; w_lights = R;
    @(posedge clk); #1;
    checks++; if ({err_conflict, err_encoding, err_sequence, err_timing, err_any, active_valid, active_dir} !== 7'd0) begin fails++; $display("FAIL reset_flags: got %b want 0", {err_conflict, err_encoding, err_sequence, err_timing, err_any, active_valid, active_dir}); end
    checks++; if ({err_count, rot_count} !== 24'd0) begin fails++; $display("FAIL reset_counts: got err_count=%0d rot_count=%0d want 0", err_count, rot_count); end
    @(negedge clk); rst_a = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++; if ({err_any, err_count, active_valid} !== 10'd0) begin fails++; $display("FAIL reset_idle: got err_any=%b err_count=%0d active_valid=%b want 0", err_any, err_count, active_valid); end
  endtask

  task automatic test_rotation();
    apply_reset();
    for (int d = 0; d < 4; d++) begin
      tick_one(d, G);
      checks++; if (active_valid !== 1'b1 || active_dir !== d[1:0]) begin fails++; $display("FAIL rot_active_dir: got valid=%b dir=%0d want valid=1 dir=%0d", active_valid, active_dir, d); end
      repeat (3) tick_one(d, G);
      repeat (2) tick_one(d, Y);
    end
    tick_lamps(R, R, R, R, 1'b0);
    checks++; if (err_any !== 1'b0) begin fails++; $display("FAIL rot_err_any: got %b want 0", err_any); end
    checks++; if (err_count !== 8'd0) begin fails++; $display("FAIL rot_err_count: got %0d want 0", err_count); end
    checks++; if (rot_count !== 16'd1) begin fails++; $display("FAIL rot_count: got %0d want 1", rot_count); end
    checks++; if (active_valid !== 1'b0 || active_dir !== 2'd3) begin fails++; $display("FAIL rot_all_red: got valid=%b dir=%0d want valid=0 dir=3", active_valid, active_dir); end
  endtask

  task automatic test_conflict();
    apply_reset();
    tick_lamps(G, R, G, R, 1'b0);
    checks++; if (err_conflict !== 1'b1) begin fails++; $display("FAIL conflict_flag: got %b want 1", err_conflict); end
    checks++; if (err_count !== 8'd1) begin fails++; $display("FAIL conflict_count: got %0d want 1", err_count); end
    checks++; if (active_valid !== 1'b0) begin fails++; $display("FAIL conflict_valid: got %b want 0", active_valid); end
    checks++; if (err_sequence !== 1'b0 || err_encoding !== 1'b0) begin fails++; $display("FAIL conflict_other: got seq=%b enc=%b want 0 0", err_sequence, err_encoding); end
  endtask

  task automatic test_encoding();
    apply_reset();
    tick_lamps(R, 3'b110, R, R, 1'b0);
    checks++; if (err_encoding !== 1'b1) begin fails++; $display("FAIL enc_flag: got %b want 1", err_encoding); end
    checks++; if (err_count !== 8'd1) begin fails++; $display("FAIL enc_count: got %0d want 1", err_count); end
    checks++; if (err_conflict !== 1'b0 || active_valid !== 1'b1 || active_dir !== 2'd1) begin fails++; $display("FAIL enc_active: got conf=%b valid=%b dir=%0d want 0 1 1", err_conflict, active_valid, active_dir); end
    tick_one(1, G);
    checks++; if (err_sequence !== 1'b0 || err_count !== 8'd1) begin fails++; $display("FAIL enc_hold_phase: got seq=%b count=%0d want 0 1", err_sequence, err_count); end
  endtask

  task automatic test_sequence();
    apply_reset();
    tick_one(0, G);
    tick_one(0, G);
    tick_lamps(R, R, R, R, 1'b0);
    checks++; if (err_sequence !== 1'b1 || err_count !== 8'd1) begin fails++; $display("FAIL seq_green_red: got seq=%b count=%0d want 1 1", err_sequence, err_count); end
    checks++; if (err_timing !== 1'b0) begin fails++; $display("FAIL seq_no_timing: got %b want 0", err_timing); end
    tick_one(2, G);
    checks++; if (err_count !== 8'd2) begin fails++; $display("FAIL seq_order: got count=%0d want 2", err_count); end
  endtask

  task automatic test_timing();
    apply_reset();
    tick_one(0, G);
    tick_one(0, Y);
    checks++; if (err_timing !== 1'b1 || err_count !== 8'd1) begin fails++; $display("FAIL tim_short_green: got tim=%b count=%0d want 1 1", err_timing, err_count); end
    checks++; if (err_sequence !== 1'b0) begin fails++; $display("FAIL tim_short_seq: got %b want 0", err_sequence); end
    apply_reset();
    for (int k = 1; k <= 13; k++) begin
      tick_one(0, G);
      if (k == 10) begin
        checks++; if (err_timing !== 1'b0 || err_count !== 8'd0) begin fails++; $display("FAIL tim_ten_green: got tim=%b count=%0d want 0 0", err_timing, err_count); end
      end
      if (k == 11) begin
        checks++; if (err_timing !== 1'b1 || err_count !== 8'd1) begin fails++; $display("FAIL tim_long_green: got tim=%b count=%0d want 1 1", err_timing, err_count); end
      end
    end
    checks++; if (err_count !== 8'd1) begin fails++; $display("FAIL tim_long_once: got count=%0d want 1", err_count); end
    tick_one(0, Y);
    checks++; if (err_count !== 8'd1) begin fails++; $display("FAIL tim_long_to_yellow: got count=%0d want 1", err_count); end
  endtask

  task automatic test_clear_reset();
    apply_reset();
    tick_lamps(R, R, R, 3'b111, 1'b0);
    checks++; if (err_encoding !== 1'b1 || err_count !== 8'd1) begin fails++; $display("FAIL clr_pre: got enc=%b count=%0d want 1 1", err_encoding, err_count); end
    tick_lamps(G, G, R, R, 1'b1);
    checks++; if (err_conflict !== 1'b1 || err_encoding !== 1'b0 || err_count !== 8'd1) begin fails++; $display("FAIL clr_with_error: got conf=%b enc=%b count=%0d want 1 0 1", err_conflict, err_encoding, err_count); end
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    checks++; if (err_any !== 1'b0 || err_count !== 8'd0) begin fails++; $display("FAIL clr_plain: got any=%b count=%0d want 0 0", err_any, err_count); end

    apply_reset();
    tick_one(1, G);
    tick_lamps(R, G, 3'b111, R, 1'b0);
    checks++; if (err_any !== 1'b1 || active_dir !== 2'd1) begin fails++; $display("FAIL midrst_pre: got any=%b dir=%0d want 1 1", err_any, active_dir); end
    @(negedge clk); #2;
    rst_a = 1'b0;
    #1;
    checks++; if ({err_conflict, err_encoding, err_sequence, err_timing, err_any, active_valid, active_dir, err_count, rot_count} !== 31'd0) begin fails++; $display("FAIL midrst_async: got count=%0d dir=%0d any=%b want all 0", err_count, active_dir, err_any); end
    @(negedge clk); rst_a = 1'b1;
    tick_one(3, G);
    checks++; if (err_any !== 1'b0 || err_count !== 8'd0) begin fails++; $display("FAIL midrst_first_green: got any=%b count=%0d want 0 0", err_any, err_count); end
    checks++; if (active_valid !== 1'b1 || active_dir !== 2'd3) begin fails++; $display("FAIL midrst_active: got valid=%b dir=%0d want 1 3", active_valid, active_dir); end
  endtask

  initial begin
    rst_a = 1'b0; clk_out = 1'b0; clr_err = 1'b0;
    n_lights = R; s_lights = R; e_lights = R; w_lights = R;
    test_reset();
    test_rotation();
    test_conflict();
    test_encoding();
    test_sequence();
    test_timing();
    test_clear_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive checker on the output side of traffic_control. It consumes the four 3-bit lamp buses and the slow clk_out strobe.
- Checks four things: safety (no conflicting right-of-way), encoding, phase sequence and dwell timing.
- Reports sticky per-class error flags, a saturating error count, the currently active direction and completed N->S->E->W rotations.
- Sits beside traffic_control in tb_top and in the FPGA top, where err_any drives a fault LED.

Parameters:
- GREEN_MIN, 2, minimum green dwell in ticks.
- GREEN_MAX, 10, maximum green dwell in ticks.
- YELLOW_TICKS, 2, exact required yellow dwell in ticks.
- ERR_CNT_W, 8, width of err_count.

Ports:
- clk  in  1  system clock, same clock as traffic_control.
- rst_a  in  1  asynchronous, active-low reset (rst_a=0 resets).
- clk_out  in  1  slow strobe from traffic_control; synchronous to clk.
- n_lights  in  3  north lamps; encoding is {red,yellow,green}.
- s_lights  in  3  south lamps.
- e_lights  in  3  east lamps.
- w_lights  in  3  west lamps.
- clr_err  in  1  synchronous clear of the flags and err_count.
- err_conflict  out  1  sticky: more than one direction was non-red.
- err_encoding  out  1  sticky: a lamp bus was not exactly one-hot.
- err_sequence  out  1  sticky: illegal phase transition or rotation order.
- err_timing  out  1  sticky: a dwell limit was violated.
- err_any  out  1  OR of the four sticky flags.
- err_count  out  ERR_CNT_W  number of ticks carrying at least one error; saturates.
- active_dir  out  2  direction holding green/yellow (0=N, 1=S, 2=E, 3=W).
- active_valid  out  1  exactly one direction is non-red.
- rot_count  out  16  completed rotations; wraps modulo 2^16.

Behaviour:
- Reset: while rst_a=0, every output is 0. Trackers go to RED with dwell=0. Expected-next-green is set to ANY. clk_out_q is cleared. Assertion is asynchronous; release is synchronous to clk.
- Tick: clk_out_q is clk_out registered. tick = clk_out_q & ~clk_out, i.e. the falling edge of clk_out, half a strobe after the controller updates. On non-tick cycles the monitor holds all state.
- Latency: lamps are sampled at the clk edge where tick=1. All outputs are registered and reflect that sample one clk later.
- Encoding check: legal codes are 100 (red), 010 (yellow), 001 (green).
  - Any other code sets err_encoding.
  - That direction's tracker holds its previous phase and dwell.
  - Its conflict contribution counts as non-red.
- Per-direction FSM (RED/GREEN/YELLOW):
  - Legal moves are hold, RED->GREEN, GREEN->YELLOW and YELLOW->RED.
  - RED->YELLOW, GREEN->RED and YELLOW->GREEN set err_sequence; the tracker still adopts the new phase.
- Dwell counter: cleared on a phase change, otherwise +1 per tick. It saturates at GREEN_MAX+1.
- Green timing:
  - GREEN->YELLOW with dwell+1 < GREEN_MIN sets err_timing.
  - The dwell crossing GREEN_MAX while still green sets err_timing once per green phase.
- Yellow timing: YELLOW->RED with dwell+1 != YELLOW_TICKS sets err_timing.
- Rotation order:
  - On a RED->GREEN for direction d, if expected != ANY and d != expected, err_sequence is set.
  - Expected then becomes (d+1) mod 4.
  - When W completes YELLOW->RED legally after a full N,S,E,W sequence, rot_count increments by 1.
- Conflict: in one sample, a count of non-red directions greater than 1 sets err_conflict.
- Active outputs: active_valid=1 and active_dir=that index when exactly one direction is non-red. Otherwise active_valid=0 and active_dir holds its last value.
- err_count: +1 per tick on which any check fires (not once per class). It saturates at all-ones.
- clr_err:
  - Clears all sticky flags and err_count on the next clk.
  - If a tick with an error coincides with clr_err, the new error wins: the flag is set and err_count=1.
  - Trackers and rot_count are not affected.
- Reset mid-phase: everything returns to reset values. The first green after release is accepted from any direction.

Decomposition:
- Package traffic_pkg holds:
  - LIGHT_RED/LIGHT_YELLOW/LIGHT_GREEN constants.
  - The dir_e enum (DIR_N..DIR_W).
  - The phase_e enum (PH_RED, PH_GREEN, PH_YELLOW).
- Sub-module traffic_dir_tracker is instantiated four times. Each instance contains the phase FSM and dwell counter, and outputs its own non_red, to_green, to_red, enc_err, seq_err and tim_err.
- The top level handles tick detection, conflict and rotation logic, flag and count registers.

Test Plan:
- Legal rotation: green 4 ticks, yellow 2 ticks per direction, N->S->E->W, then W back to red -> no flags, err_count=0, rot_count=1; active_dir steps 0,1,2,3.
- Conflict: N=001 and E=001 on one tick -> err_conflict=1 and err_count=1 one clk later; active_valid=0.
- Encoding: S=110 for one tick -> err_encoding=1; S tracker phase is unchanged; err_count=1.
- Sequence: N GREEN->RED directly -> err_sequence=1. Then E goes green while S is expected -> err_count=2.
- Timing: green 1 tick (GREEN_MIN=2) -> err_timing=1. Separately, green held 11 ticks -> err_timing set exactly once and err_count incremented once.
- Clear and reset: clr_err asserted on the same clk as a conflict tick -> err_conflict=1, err_count=1. rst_a pulsed low mid-green -> all outputs 0 immediately; the next green from W is accepted with no error.
